seg_scan_driver: RTL

- Time-multiplexed driver for the Basys 4-digit seven-segment display.
- Game/menu logic loads a packed 4-digit glyph word through a single-cycle load strobe. The block owns all seg/an/dp timing: scanning, blanking and blinking.
- Menu code no longer hand-sequences seg/an.
- Sits between the menu/game FSMs and the board seg/an/dp pins.

---
 rtl/seg_scan_driver.sv | 101 ++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit seven-segment driver with shadow load, blanking and blink
module seg_scan_driver #(
    parameter int SCAN_DIV  = 250_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  digit_en_in,
    input  logic [3:0]  blink_in,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [SW-1:0] r_scan;
    logic [BW-1:0] r_bcnt;
    logic [1:0]    r_idx;
    logic          r_phase;
    logic [15:0]   r_digits;
    logic [3:0]    r_en, r_blink, r_dp;

    logic          w_scan_wrap, w_blink_wrap, w_vis;
    logic [1:0]    w_k;
    logic [3:0]    w_glyph, w_an;
    logic [6:0]    w_seg;

    assign w_scan_wrap  = r_scan == SW'(SCAN_DIV - 1);
    assign w_blink_wrap = r_bcnt == BW'(BLINK_DIV - 1);
    assign w_k          = 2'd3 - r_idx;
    assign w_glyph      = r_digits[{w_k, 2'b00} +: 4];
    assign w_vis        = r_en[w_k] & ~(r_blink[w_k] & r_phase);
    assign w_an         = ~(4'b0001 << w_k);

    // Glyph code to active-low {g,f,e,d,c,b,a}; E/F light nothing but still drive the anode
    always_comb begin
        w_seg = 7'h7F;
        case (w_glyph)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001100;
            4'hB: w_seg = 7'b0111111;
            4'hC: w_seg = 7'b1000111;
            4'hD: w_seg = 7'b0001000;
            default: w_seg = 7'h7F;
        endcase
    end

    // Free-running scan/blink timebases and shadow capture; load never touches the counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scan   <= '0;
            r_bcnt   <= '0;
            r_idx    <= '0;
            r_phase  <= 1'b0;
            r_digits <= '0;
            r_en     <= '0;
            r_blink  <= '0;
            r_dp     <= '0;
        end else begin
            r_scan <= w_scan_wrap ? '0 : r_scan + 1'b1;
            r_idx  <= w_scan_wrap ? r_idx + 2'd1 : r_idx;
            r_bcnt <= w_blink_wrap ? '0 : r_bcnt + 1'b1;
            r_phase <= w_blink_wrap ? ~r_phase : r_phase;
            if (load) begin
                r_digits <= digits_in;
                r_en     <= digit_en_in;
                r_blink  <= blink_in;
                r_dp     <= dp_in;
            end
        end
    end

    // Registered pins: a hidden digit releases every anode so at most one is ever low
    always_ff @(posedge clock) begin
        if (reset) begin
            seg        <= 7'h7F;
            an         <= 4'hF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            seg        <= w_vis ? w_seg : 7'h7F;
            an         <= w_vis ? w_an : 4'hF;
            dp         <= ~(w_vis & r_dp[w_k]);
            frame_done <= w_scan_wrap && r_idx == 2'd3;
        end
    end
endmodule
